x_stage_md: RTL and testbench
=============================

X_STAGE_MD -- requirements
Module: x_stage_md

Interface
REQ-001 Parameter N_BITS, default 32: datapath width; SHALL be even and >= 8.
REQ-002 Parameter TAG_W, default 16: width of the opaque side-band packet (writeback/dmem control) carried alongside each instruction.
REQ-003 Parameter MD_EN, default 1: 1 = multiply/divide ops implemented; 0 = MD ops return 0 with ALU latency.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  upstream offers an instruction.
REQ-007 in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready.
REQ-008 in_op  in  5  operation code (REQ-013).
REQ-009 in_op1, in_op2  in  N_BITS  operands.
REQ-010 in_sel_pc4  in  1  1 = result is in_pc_plus4 (JAL/JALR link); 0 = ALU/MD result.
REQ-011 in_pc_plus4  in  N_BITS; in_tag  in  TAG_W  side-band, returned unmodified on out_tag.
REQ-012 flush  in  1  kill held/in-flight instruction; out_valid, out_ready  out/in  1  downstream handshake; out_data  out  N_BITS; out_tag  out  TAG_W; busy  out  1  high while MD iteration in progress.

Function
REQ-013 Op codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_OP2; 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; any other code yields 0 with ALU latency.
REQ-014 Shifts use in_op2[$clog2(N_BITS)-1:0] only; SLT/SLTU yield 0 or 1 zero-extended; all arithmetic modulo 2^N_BITS.
REQ-015 MUL returns low N_BITS of product; MULH/MULHSU/MULHU return high N_BITS with signed*signed, signed*unsigned (op1 signed), unsigned*unsigned operands respectively.
REQ-016 Divide by zero: DIV/DIVU = all ones, REM/REMU = op1; DIV overflow (most-negative / -1) = most-negative, REM = 0; signed REM takes sign of op1.
REQ-017 States: IDLE (nothing held), RUN (MD iterating), HOLD (result valid on outputs).
REQ-018 in_ready = !flush && (state==IDLE || (state==HOLD && out_ready)).
REQ-019 Accept of ALU op, unknown op, MD op with MD_EN=0, or any op with in_sel_pc4=1: next state HOLD; out_valid, out_data, out_tag registered from that instruction the following cycle (latency 1).
REQ-020 Accept of MD op with MD_EN=1 and in_sel_pc4=0: next state RUN; iteration counter loaded with N_BITS; operands, op, tag captured; busy high from next cycle.
REQ-021 RUN: one shift-add (multiply) or restoring subtract-shift (divide) step per cycle on magnitudes; counter decrements; on counter reaching 0 next state HOLD with sign-corrected result; out_valid first high exactly N_BITS+1 cycles after accept cycle, including REQ-016 cases.
REQ-022 in_valid/in_op/operands ignored while in RUN; in_ready is 0 in RUN.
REQ-023 HOLD: out_valid=1; out_data/out_tag stable until out_ready; on out_ready with no accept -> IDLE; on out_ready with simultaneous accept -> new instruction per REQ-019/020 (back-to-back ALU throughput 1/cycle).
REQ-024 HOLD with out_ready=0: all outputs held, in_ready=0.
REQ-025 flush=1: next state IDLE, out_valid=0 and busy=0 next cycle, RUN aborted, no accept that cycle; flush in IDLE is harmless.
REQ-026 out_data and out_tag SHALL be 0 whenever out_valid=0.

Reset
REQ-027 rst_n=0 sampled at a clock edge: state IDLE, counter 0, out_valid=0, out_data=0, out_tag=0, busy=0; in_ready=1 first cycle after release.
REQ-028 Reset has priority over flush and handshakes; reset mid-RUN discards the operation with no output.

Verification
REQ-029 N_BITS=32: ADD 0xFFFFFFFF+1, out_ready=1 -> out_valid next cycle, out_data=0, out_tag echoed.
REQ-030 MULH -2 x 3 accepted cycle 0 -> busy cycles 1-32, out_valid cycle 33, out_data=0xFFFFFFFF; MUL same operands -> 0xFFFFFFFA.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; REM -7/2 -> 0xFFFFFFFF.
REQ-032 Four back-to-back ADDs, out_ready=0 for 3 cycles after first result -> first result held stable, in_ready=0, no loss or duplication, all four results in order.
REQ-033 in_sel_pc4=1 with op DIV, pc_plus4=0x104 -> out_data=0x104 at latency 1, busy never high.
REQ-034 flush at RUN cycle 10 -> out_valid never asserts for that op, in_ready=1 next cycle; rst_n=0 mid-RUN -> all outputs 0.

Source files
------------

// File: rtl/x_stage_md.sv
// x_stage_md: execute stage holding one instruction at a time.
// Single-cycle ALU operations and link-address (PC+4) results appear on the
// outputs one cycle after acceptance. Multiply and divide operations run
// bit-serially for N_BITS cycles before the result is presented.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   in_op               5-bit operation code (ALU 0..10, MD 16..23)
//   in_op1, in_op2      operands
//   in_sel_pc4          select in_pc_plus4 as the result (link)
//   in_pc_plus4         link address
//   in_tag              side-band packet, echoed on out_tag
//   flush               kill held / in-flight instruction
//   out_valid/out_ready downstream handshake
//   out_data, out_tag   result and echoed tag (zero when out_valid=0)
//   busy                multiply/divide iteration in progress
module x_stage_md #(
    parameter int N_BITS = 32,
    parameter int TAG_W  = 16,
    parameter int MD_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [N_BITS-1:0] in_op1,
    input  logic [N_BITS-1:0] in_op2,
    input  logic              in_sel_pc4,
    input  logic [N_BITS-1:0] in_pc_plus4,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int SH_W  = $clog2(N_BITS);
    localparam int CNT_W = $clog2(N_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [N_BITS-1:0] acc_hi_q;
    logic [N_BITS-1:0] acc_lo_q;
    logic [N_BITS-1:0] opb_q;
    logic [2:0]        md_op_q;
    logic              mul_neg_q;
    logic              quo_neg_q;
    logic              rem_neg_q;
    logic [TAG_W-1:0]  md_tag_q;

    logic              out_valid_q;
    logic [N_BITS-1:0] out_data_q;
    logic [TAG_W-1:0]  out_tag_q;

    logic              accept;
    logic              is_md;
    logic              start_md;
    logic [N_BITS-1:0] alu_res;
    logic [SH_W-1:0]   shamt;

    logic              op1_signed;
    logic              op2_signed;
    logic              s1;
    logic              s2;
    logic [N_BITS-1:0] mag1;
    logic [N_BITS-1:0] mag2;

    logic [N_BITS:0]     mul_sum;
    logic [N_BITS:0]     div_shift;
    logic [N_BITS:0]     div_diff;
    logic [N_BITS-1:0]   step_hi;
    logic [N_BITS-1:0]   step_lo;
    logic [2*N_BITS-1:0] prod;
    logic [2*N_BITS-1:0] prod_fix;
    logic [N_BITS-1:0]   quo_fix;
    logic [N_BITS-1:0]   rem_fix;
    logic [N_BITS-1:0]   md_result;

    // Handshake: a held result blocks new work unless it is being consumed
    // this same cycle; flush always refuses the incoming instruction.
    assign in_ready = !flush && ((state_q == S_IDLE) ||
                                 ((state_q == S_HOLD) && out_ready));
    assign accept   = in_valid && in_ready;
    assign is_md    = (in_op[4:3] == 2'b10);
    assign start_md = is_md && (MD_EN != 0) && !in_sel_pc4;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign busy      = (state_q == S_RUN);

    // Single-cycle ALU. Codes outside the table, including MD codes that
    // take this path, fall through to zero.
    always_comb begin
        alu_res = '0;
        shamt   = in_op2[SH_W-1:0];
        case (in_op)
            5'd0:  alu_res = in_op1 + in_op2;
            5'd1:  alu_res = in_op1 - in_op2;
            5'd2:  alu_res = in_op1 << shamt;
            5'd3:  alu_res = {{(N_BITS-1){1'b0}}, ($signed(in_op1) < $signed(in_op2))};
            5'd4:  alu_res = {{(N_BITS-1){1'b0}}, (in_op1 < in_op2)};
            5'd5:  alu_res = in_op1 ^ in_op2;
            5'd6:  alu_res = in_op1 >> shamt;
            5'd7:  alu_res = N_BITS'($signed(in_op1) >>> shamt);
            5'd8:  alu_res = in_op1 | in_op2;
            5'd9:  alu_res = in_op1 & in_op2;
            5'd10: alu_res = in_op2;
            default: alu_res = '0;
        endcase
    end

    // Operand preparation for the serial unit: the iteration works on
    // magnitudes and the sign is reapplied once at the end.
    // MD sub-op in_op[2:0]: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
    // 4 DIV, 5 DIVU, 6 REM, 7 REMU.
    always_comb begin
        op1_signed = (in_op[2:0] == 3'd1) || (in_op[2:0] == 3'd2) ||
                     (in_op[2:0] == 3'd4) || (in_op[2:0] == 3'd6);
        op2_signed = (in_op[2:0] == 3'd1) || (in_op[2:0] == 3'd4) ||
                     (in_op[2:0] == 3'd6);
        s1   = op1_signed && in_op1[N_BITS-1];
        s2   = op2_signed && in_op2[N_BITS-1];
        mag1 = s1 ? -in_op1 : in_op1;
        mag2 = s2 ? -in_op2 : in_op2;
    end

    // One iteration step plus final sign correction. For multiply acc_lo
    // holds the remaining multiplier bits and acc_hi the running partial
    // product; for divide acc_lo holds dividend bits being shifted out while
    // quotient bits shift in, and acc_hi is the partial remainder. A zero
    // divisor naturally yields an all-ones quotient and the dividend as
    // remainder, so only the quotient sign needs suppressing in that case.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[N_BITS-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        step_hi   = '0;
        step_lo   = '0;
        if (md_op_q[2]) begin
            if (!div_diff[N_BITS]) begin
                step_hi = div_diff[N_BITS-1:0];
                step_lo = {acc_lo_q[N_BITS-2:0], 1'b1};
            end else begin
                step_hi = div_shift[N_BITS-1:0];
                step_lo = {acc_lo_q[N_BITS-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[N_BITS:1];
            step_lo = {mul_sum[0], acc_lo_q[N_BITS-1:1]};
        end

        prod     = {step_hi, step_lo};
        prod_fix = mul_neg_q ? -prod : prod;
        quo_fix  = quo_neg_q ? -step_lo : step_lo;
        rem_fix  = rem_neg_q ? -step_hi : step_hi;

        md_result = '0;
        case (md_op_q)
            3'd0:       md_result = prod_fix[N_BITS-1:0];
            3'd1, 3'd2,
            3'd3:       md_result = prod_fix[2*N_BITS-1:N_BITS];
            3'd4, 3'd5: md_result = quo_fix;
            default:    md_result = rem_fix;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A new accept from HOLD reuses the same decision as
    // from IDLE, giving one ALU result per cycle when downstream is ready.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = start_md ? S_RUN : S_HOLD;
                    end
                end
                S_RUN: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        state_d = start_md ? S_RUN : S_HOLD;
                    end else if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output registers. The final iteration writes its
    // sign-corrected result straight into the output register so the result
    // is visible the cycle after the counter expires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opb_q       <= '0;
            md_op_q     <= '0;
            mul_neg_q   <= 1'b0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            md_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else if (flush) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else if (accept) begin
            if (start_md) begin
                cnt_q       <= CNT_W'(N_BITS);
                acc_hi_q    <= '0;
                acc_lo_q    <= mag1;
                opb_q       <= mag2;
                md_op_q     <= in_op[2:0];
                mul_neg_q   <= s1 ^ s2;
                quo_neg_q   <= (s1 ^ s2) && (in_op2 != '0);
                rem_neg_q   <= s1;
                md_tag_q    <= in_tag;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                out_tag_q   <= '0;
            end else begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_sel_pc4 ? in_pc_plus4 : alu_res;
                out_tag_q   <= in_tag;
            end
        end else if (state_q == S_RUN) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            cnt_q    <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                out_valid_q <= 1'b1;
                out_data_q  <= md_result;
                out_tag_q   <= md_tag_q;
            end
        end else if ((state_q == S_HOLD) && out_ready) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end
    end

endmodule

// File: tb/tb_x_stage_md.sv
// tb_x_stage_md: directed test of x_stage_md at N_BITS=32, TAG_W=16.
// A table of single operations with hand-computed results and latencies is
// applied one at a time, followed by hand-written sequences for
// back-to-back throughput with a downstream stall, flush during an
// iteration, and reset during an iteration.
module tb_x_stage_md;

    localparam int N_BITS = 32;
    localparam int TAG_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [N_BITS-1:0] in_op1;
    logic [N_BITS-1:0] in_op2;
    logic              in_sel_pc4;
    logic [N_BITS-1:0] in_pc_plus4;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [N_BITS-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    x_stage_md #(
        .N_BITS(N_BITS),
        .TAG_W (TAG_W),
        .MD_EN (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_op1     (in_op1),
        .in_op2     (in_op2),
        .in_sel_pc4 (in_sel_pc4),
        .in_pc_plus4(in_pc_plus4),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sel;
        logic [31:0] pc4;
        logic [15:0] tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic sel,
                                input logic [31:0] pc4, input logic [15:0] tag,
                                input logic [31:0] exp, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sel = sel; v.pc4 = pc4;
        v.tag = tag; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Offer one instruction, then wait (bounded) for its result while
    // measuring latency and busy cycles; downstream is always ready here.
    task automatic applyStimulus(input vec_t v, input string name);
        int lat;
        int busy_cnt;
        int exp_busy;
        @(negedge clk);
        in_valid    = 1'b1;
        in_op       = v.op;
        in_op1      = v.a;
        in_op2      = v.b;
        in_sel_pc4  = v.sel;
        in_pc_plus4 = v.pc4;
        in_tag      = v.tag;
        out_ready   = 1'b1;
        #1;
        checkOutput({name, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        busy_cnt = busy ? 1 : 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end
        exp_busy = (v.lat > 1) ? v.lat - 1 : 0;
        checkOutput({name, " latency"}, 32'(lat), 32'(v.lat));
        checkOutput({name, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
        checkOutput({name, " data"}, out_data, v.exp);
        checkOutput({name, " tag"}, 32'(out_tag), 32'(v.tag));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int sent;
        int got;
        int vcount;
        logic [31:0] bb_a[4];
        logic [31:0] bb_b[4];
        logic [31:0] bb_exp[4];

        // ALU table
        vecs.push_back(mk(5'd0,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0, 16'hA5A5, 32'h00000000, 1));
        vecs.push_back(mk(5'd1,  32'h00000005, 32'h00000007, 1'b0, 32'h0, 16'h0001, 32'hFFFFFFFE, 1));
        vecs.push_back(mk(5'd2,  32'h00000001, 32'h00000025, 1'b0, 32'h0, 16'h0002, 32'h00000020, 1));
        vecs.push_back(mk(5'd3,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0, 16'h0003, 32'h00000001, 1));
        vecs.push_back(mk(5'd4,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0, 16'h0004, 32'h00000000, 1));
        vecs.push_back(mk(5'd5,  32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h0, 16'h0005, 32'hFF00FF00, 1));
        vecs.push_back(mk(5'd6,  32'h80000000, 32'h00000004, 1'b0, 32'h0, 16'h0006, 32'h08000000, 1));
        vecs.push_back(mk(5'd7,  32'h80000000, 32'h00000004, 1'b0, 32'h0, 16'h0007, 32'hF8000000, 1));
        vecs.push_back(mk(5'd8,  32'h12340000, 32'h00005678, 1'b0, 32'h0, 16'h0008, 32'h12345678, 1));
        vecs.push_back(mk(5'd9,  32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 32'h0, 16'h0009, 32'h0F000F00, 1));
        vecs.push_back(mk(5'd10, 32'h11111111, 32'hDEADBEEF, 1'b0, 32'h0, 16'h000A, 32'hDEADBEEF, 1));
        vecs.push_back(mk(5'd11, 32'h00000003, 32'h00000004, 1'b0, 32'h0, 16'h000B, 32'h00000000, 1));
        vecs.push_back(mk(5'd31, 32'h00000003, 32'h00000004, 1'b0, 32'h0, 16'h000C, 32'h00000000, 1));
        // Multiply / divide table
        vecs.push_back(mk(5'd16, 32'hFFFFFFFE, 32'h00000003, 1'b0, 32'h0, 16'h1000, 32'hFFFFFFFA, 33));
        vecs.push_back(mk(5'd17, 32'hFFFFFFFE, 32'h00000003, 1'b0, 32'h0, 16'h1001, 32'hFFFFFFFF, 33));
        vecs.push_back(mk(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 16'h1002, 32'hFFFFFFFE, 33));
        vecs.push_back(mk(5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 16'h1003, 32'hFFFFFFFF, 33));
        vecs.push_back(mk(5'd17, 32'h80000000, 32'h80000000, 1'b0, 32'h0, 16'h1004, 32'h40000000, 33));
        vecs.push_back(mk(5'd20, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 16'h1005, 32'h80000000, 33));
        vecs.push_back(mk(5'd22, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 16'h1006, 32'h00000000, 33));
        vecs.push_back(mk(5'd21, 32'h00000007, 32'h00000000, 1'b0, 32'h0, 16'h1007, 32'hFFFFFFFF, 33));
        vecs.push_back(mk(5'd23, 32'h00000007, 32'h00000000, 1'b0, 32'h0, 16'h1008, 32'h00000007, 33));
        vecs.push_back(mk(5'd22, 32'hFFFFFFF9, 32'h00000002, 1'b0, 32'h0, 16'h1009, 32'hFFFFFFFF, 33));
        vecs.push_back(mk(5'd20, 32'hFFFFFFF9, 32'h00000002, 1'b0, 32'h0, 16'h100A, 32'hFFFFFFFD, 33));
        vecs.push_back(mk(5'd20, 32'hFFFFFFF9, 32'h00000000, 1'b0, 32'h0, 16'h100B, 32'hFFFFFFFF, 33));
        vecs.push_back(mk(5'd22, 32'hFFFFFFF9, 32'h00000000, 1'b0, 32'h0, 16'h100C, 32'hFFFFFFF9, 33));
        vecs.push_back(mk(5'd21, 32'h00000064, 32'h00000007, 1'b0, 32'h0, 16'h100D, 32'h0000000E, 33));
        vecs.push_back(mk(5'd23, 32'h00000064, 32'h00000007, 1'b0, 32'h0, 16'h100E, 32'h00000002, 33));
        // Link-address selection overrides the operation
        vecs.push_back(mk(5'd20, 32'h00000064, 32'h00000007, 1'b1, 32'h00000104, 16'h2000, 32'h00000104, 1));
        vecs.push_back(mk(5'd0,  32'h00000064, 32'h00000007, 1'b1, 32'h00000200, 16'h2001, 32'h00000200, 1));

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_op       = '0;
        in_op1      = '0;
        in_op2      = '0;
        in_sel_pc4  = 1'b0;
        in_pc_plus4 = '0;
        in_tag      = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_data", out_data, 32'd0);
        checkOutput("reset out_tag", 32'(out_tag), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);

        // Table-driven single operations
        vcount = vecs.size();
        for (int i = 0; i < vcount; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d op%0d", i, vecs[i].op));
        end

        // Back-to-back ADDs with a 3-cycle stall on the first result
        bb_a[0] = 32'h00000001; bb_b[0] = 32'h00000002; bb_exp[0] = 32'h00000003;
        bb_a[1] = 32'hFFFFFFFF; bb_b[1] = 32'hFFFFFFFF; bb_exp[1] = 32'hFFFFFFFE;
        bb_a[2] = 32'h7FFFFFFF; bb_b[2] = 32'h00000001; bb_exp[2] = 32'h80000000;
        bb_a[3] = 32'h00000064; bb_b[3] = 32'h000000C8; bb_exp[3] = 32'h0000012C;
        sent = 0;
        got  = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            out_ready = !(cyc >= 1 && cyc <= 3);
            if (sent < 4) begin
                in_valid   = 1'b1;
                in_op      = 5'd0;
                in_op1     = bb_a[sent];
                in_op2     = bb_b[sent];
                in_sel_pc4 = 1'b0;
                in_tag     = 16'(16'h0100 + sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 1 && cyc <= 3) begin
                checkOutput($sformatf("stall%0d out_valid", cyc), 32'(out_valid), 32'd1);
                checkOutput($sformatf("stall%0d data", cyc), out_data, bb_exp[0]);
                checkOutput($sformatf("stall%0d in_ready", cyc), 32'(in_ready), 32'd0);
            end
            if (out_valid && got < 4) begin
                checkOutput($sformatf("b2b%0d data", got), out_data, bb_exp[got]);
                checkOutput($sformatf("b2b%0d tag", got), 32'(out_tag), 32'(16'h0100 + got));
                if (out_ready) got++;
            end
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("b2b results received", 32'(got), 32'd4);
        checkOutput("b2b accepted", 32'(sent), 32'd4);
        checkOutput("b2b drained out_valid", 32'(out_valid), 32'd0);
        checkOutput("b2b drained out_data", out_data, 32'd0);

        // Flush in the tenth RUN cycle
        begin
            int seen;
            @(negedge clk);
            in_valid   = 1'b1;
            in_op      = 5'd20;
            in_op1     = 32'h00000064;
            in_op2     = 32'h00000007;
            in_sel_pc4 = 1'b0;
            in_tag     = 16'h3000;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            repeat (9) @(negedge clk);
            checkOutput("flush busy before", 32'(busy), 32'd1);
            flush = 1'b1;
            #1;
            checkOutput("flush in_ready during", 32'(in_ready), 32'd0);
            @(negedge clk);
            flush = 1'b0;
            #1;
            checkOutput("flush busy after", 32'(busy), 32'd0);
            checkOutput("flush out_valid after", 32'(out_valid), 32'd0);
            checkOutput("flush in_ready after", 32'(in_ready), 32'd1);
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            checkOutput("flush no result", 32'(seen), 32'd0);
        end

        // Reset during an iteration
        begin
            int seen;
            @(negedge clk);
            in_valid   = 1'b1;
            in_op      = 5'd16;
            in_op1     = 32'h00000005;
            in_op2     = 32'h00000006;
            in_sel_pc4 = 1'b0;
            in_tag     = 16'h4000;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            repeat (4) @(negedge clk);
            checkOutput("rstrun busy before", 32'(busy), 32'd1);
            rst_n = 1'b0;
            @(negedge clk);
            checkOutput("rstrun out_valid", 32'(out_valid), 32'd0);
            checkOutput("rstrun out_data", out_data, 32'd0);
            checkOutput("rstrun out_tag", 32'(out_tag), 32'd0);
            checkOutput("rstrun busy", 32'(busy), 32'd0);
            rst_n = 1'b1;
            #1;
            checkOutput("rstrun in_ready", 32'(in_ready), 32'd1);
            seen = 0;
            repeat (40) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            checkOutput("rstrun no result", 32'(seen), 32'd0);
        end

        // Recovery after flush and reset
        applyStimulus(mk(5'd1, 32'h00000010, 32'h00000001, 1'b0, 32'h0, 16'h5000,
                         32'h0000000F, 1), "recover sub");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
